// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand sequencer and result capture for an NxN systolic array
// Streams column k of A and row k of B per cycle, then waits for the array result.
module systolic_feeder #(
    parameter int N       = 3,
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*N*DW-1:0]   mat_a,
    input  logic [N*N*DW-1:0]   mat_b,
    output logic                arr_clr_n,
    output logic [N*DW-1:0]     arr_a,
    output logic [N*DW-1:0]     arr_b,
    input  logic [N*N*CW-1:0]   arr_c,
    input  logic                arr_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*CW-1:0]   out_c,
    output logic                busy,
    output logic                err
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_HOLD} state_t;

    state_t            state, state_n;
    logic [KW-1:0]     k, k_n;
    logic [TW-1:0]     cnt;
    logic [N*N*DW-1:0] a_lat, b_lat;
    logic              accept, timeout;

    assign accept  = (state == S_IDLE) && in_valid && in_ready;
    assign timeout = (state == S_FLUSH) && !arr_valid && (cnt == TW'(TIMEOUT - 1));

    function automatic logic [N*DW-1:0] col_of(input logic [N*N*DW-1:0] m, input logic [KW-1:0] kk);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = m[(i*N + int'(kk))*DW +: DW];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] row_of(input logic [N*N*DW-1:0] m, input logic [KW-1:0] kk);
        logic [N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = m[(int'(kk)*N + j)*DW +: DW];
        return r;
    endfunction

    always_comb begin
        state_n = state;
        k_n     = k;
        case (state)
            S_IDLE:   if (accept) state_n = S_CLEAR;
            S_CLEAR: begin
                state_n = S_STREAM;
                k_n     = '0;
            end
            S_STREAM: begin
                if (k == KW'(N - 1)) state_n = S_FLUSH;
                else                 k_n     = k + KW'(1);
            end
            S_FLUSH: begin
                if (arr_valid)    state_n = S_HOLD;
                else if (timeout) state_n = S_IDLE;
            end
            S_HOLD:   if (out_valid && out_ready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            cnt       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            arr_a     <= '0;
            arr_b     <= '0;
            arr_clr_n <= 1'b1;
            out_c     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            if (accept) begin
                a_lat <= mat_a;
                b_lat <= mat_b;
            end
            if (state != S_FLUSH)           cnt <= '0;
            else if (cnt != TW'(TIMEOUT))   cnt <= cnt + TW'(1);
            if (state_n == S_STREAM) begin
                arr_a <= col_of(a_lat, k_n);
                arr_b <= row_of(b_lat, k_n);
            end else begin
                arr_a <= '0;
                arr_b <= '0;
            end
            arr_clr_n <= (state_n != S_CLEAR);
            if (state == S_FLUSH && arr_valid) out_c <= arr_c;
            out_valid <= (state_n == S_HOLD);
            busy      <= (state_n != S_IDLE);
            in_ready  <= (state_n == S_IDLE);
            if (accept)       err <= 1'b0;
            else if (timeout) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder
// Outer-product array model plus plain matrix-multiply reference.
module tb_systolic_feeder;
    localparam int N = 3, DW = 8, CW = 16, TIMEOUT = 64;
    localparam int MW = N*N*DW, RW = N*N*CW, LW = N*DW;

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, in_ready, arr_clr_n, arr_valid = 1'b0, out_valid, out_ready = 1'b0, busy, err;
    logic [MW-1:0] mat_a = '0, mat_b = '0;
    logic [LW-1:0] arr_a, arr_b;
    logic [RW-1:0] arr_c = '0, out_c;

    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mat_a(mat_a), .mat_b(mat_b), .arr_clr_n(arr_clr_n), .arr_a(arr_a), .arr_b(arr_b),
        .arr_c(arr_c), .arr_valid(arr_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .busy(busy), .err(err)
    );

    // Array model: clear on arr_clr_n, accumulate the outer product of each beat.
    logic [CW-1:0] acc [N][N];
    bit arr_en = 1'b1, act = 1'b0;
    int mcnt = 0, lat = 1;
    always @(negedge clk) begin
        if (!rst) begin
            act = 1'b0; arr_valid = 1'b0;
        end else if (!arr_clr_n) begin
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
            act = 1'b1; mcnt = 0; arr_valid = 1'b0;
        end else if (act) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] = acc[i][j] + CW'(int'(arr_a[i*DW +: DW]) * int'(arr_b[j*DW +: DW]));
            mcnt++;
            if (arr_en && mcnt == N + lat) begin
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) arr_c[(i*N+j)*CW +: CW] = acc[i][j];
                arr_valid = 1'b1;
                act = 1'b0;
            end
        end
    end

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [MW-1:0] seq_mat();
        logic [MW-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    function automatic logic [MW-1:0] ident(input int s);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[(i*N+i)*DW +: DW] = DW'(s);
        return r;
    endfunction

    function automatic logic [RW-1:0] ref_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [RW-1:0] r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int q = 0; q < N; q++) s += int'(a[(i*N+q)*DW +: DW]) * int'(b[(q*N+j)*DW +: DW]);
                r[(i*N+j)*CW +: CW] = CW'(s);
            end
        return r;
    endfunction

    function automatic logic [LW-1:0] lane_col(input logic [MW-1:0] m, input int kk);
        logic [LW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = m[(i*N+kk)*DW +: DW];
        return r;
    endfunction

    function automatic logic [LW-1:0] lane_row(input logic [MW-1:0] m, input int kk);
        logic [LW-1:0] r;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = m[(kk*N+j)*DW +: DW];
        return r;
    endfunction

    // Observations from the last do_op call
    logic [RW-1:0] c_got;
    logic [LW-1:0] log_a [0:N], log_b [0:N];
    int  clr_low, acc_wait;
    bit  clr_first, got, stable_ok, inrdy_ok, drop_ok, rdy_after, err_c1;

    // Call at a negedge. Offers a/b, scrambles the inputs after accept, logs beats and result.
    task automatic do_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int hold_lo);
        int w;
        mat_a = a; mat_b = b; in_valid = 1'b1; out_ready = 1'b0;
        lat = $urandom_range(0, 4);
        for (w = 0; w < 50; w++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        acc_wait = w;
        @(negedge clk);
        in_valid = 1'b0; mat_a = rand_mat(); mat_b = rand_mat();
        clr_low = 0; clr_first = !arr_clr_n; err_c1 = err; got = 1'b0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (!arr_clr_n) clr_low++;
            if (cyc >= 2 && cyc <= N + 2) begin log_a[cyc-2] = arr_a; log_b[cyc-2] = arr_b; end
            if (out_valid) begin got = 1'b1; break; end
            if (err) break;
            @(negedge clk);
        end
        stable_ok = 1'b1; inrdy_ok = 1'b1; drop_ok = 1'b0; rdy_after = 1'b0; c_got = out_c;
        if (got) begin
            repeat (hold_lo) begin
                @(negedge clk);
                if (out_c !== c_got || !out_valid) stable_ok = 1'b0;
                if (in_ready) inrdy_ok = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            drop_ok = !out_valid; rdy_after = in_ready;
            out_ready = 1'b0;
        end
    endtask

    task automatic check_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b);
        nvec++; if (!got) begin nerr++; $display("FAIL %s result: out_valid never rose", tag); end
        nvec++; if (c_got !== ref_mul(a, b)) begin nerr++; $display("FAIL %s out_c: got %h want %h", tag, c_got, ref_mul(a, b)); end
        nvec++; if (clr_low != 1 || !clr_first) begin nerr++; $display("FAIL %s clear: low %0d cycles, first %0d want 1,1", tag, clr_low, clr_first); end
        for (int q = 0; q < N; q++) begin
            nvec++; if (log_a[q] !== lane_col(a, q)) begin nerr++; $display("FAIL %s arr_a k=%0d: got %h want %h", tag, q, log_a[q], lane_col(a, q)); end
            nvec++; if (log_b[q] !== lane_row(b, q)) begin nerr++; $display("FAIL %s arr_b k=%0d: got %h want %h", tag, q, log_b[q], lane_row(b, q)); end
        end
        nvec++; if (log_a[N] !== '0 || log_b[N] !== '0) begin nerr++; $display("FAIL %s flush lanes: got %h/%h want 0", tag, log_a[N], log_b[N]); end
        nvec++; if (!drop_ok) begin nerr++; $display("FAIL %s out_valid drop: still 1 want 0", tag); end
    endtask

    task automatic test_basic();
        logic [MW-1:0] a;
        logic [RW-1:0] e;
        a = seq_mat();
        e = {CW'(150), CW'(126), CW'(102), CW'(96), CW'(81), CW'(66), CW'(42), CW'(36), CW'(30)};
        do_op(a, a, 0);
        check_op("basic", a, a);
        nvec++; if (c_got !== e) begin nerr++; $display("FAIL basic literal: got %h want %h", c_got, e); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        mat_a = rand_mat(); mat_b = rand_mat(); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL reset pre busy: got %b want 1", busy); end
        @(posedge clk); #3 rst = 1'b0; #1;
        nvec++; if (arr_a !== '0 || arr_b !== '0) begin nerr++; $display("FAIL reset lanes: got %h/%h want 0", arr_a, arr_b); end
        nvec++; if (out_c !== '0) begin nerr++; $display("FAIL reset out_c: got %h want 0", out_c); end
        nvec++; if ({out_valid, err, busy, arr_clr_n} !== 4'b0001) begin nerr++; $display("FAIL reset flags: got %b want 0001", {out_valid, err, busy, arr_clr_n}); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL reset release: in_ready %b busy %b want 1 0", in_ready, busy); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [MW-1:0] a, b;
            a = rand_mat(); b = rand_mat();
            do_op(a, b, $urandom_range(0, 3));
            check_op("random", a, b);
        end
    endtask

    task automatic test_hold();
        logic [MW-1:0] a;
        a = seq_mat();
        do_op(a, a, 5);
        check_op("hold", a, a);
        nvec++; if (!stable_ok) begin nerr++; $display("FAIL hold stable: out_c/out_valid changed want stable"); end
        nvec++; if (!inrdy_ok) begin nerr++; $display("FAIL hold in_ready: got 1 want 0"); end
    endtask

    task automatic test_timeout();
        int w;
        bit ov_seen;
        logic [MW-1:0] a, b;
        arr_en = 1'b0; ov_seen = 1'b0;
        mat_a = rand_mat(); mat_b = rand_mat(); in_valid = 1'b1;
        for (w = 0; w < 50; w++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        for (int c = 1; c <= N + 2 + TIMEOUT; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) ov_seen = 1'b1;
            if (c == N + 1 + TIMEOUT) begin
                nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL timeout early err: got %b want 0", err); end
            end
        end
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL timeout err: got %b want 1", err); end
        nvec++; if (busy !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL timeout idle: busy %b in_ready %b want 0 1", busy, in_ready); end
        nvec++; if (ov_seen) begin nerr++; $display("FAIL timeout out_valid: got 1 want 0"); end
        arr_en = 1'b1;
        a = rand_mat(); b = rand_mat();
        do_op(a, b, 0);
        nvec++; if (err_c1 !== 1'b0) begin nerr++; $display("FAIL timeout clear: err %b want 0", err_c1); end
        check_op("after_timeout", a, b);
    endtask

    task automatic test_midreset();
        bit ov_seen;
        logic [MW-1:0] a, b;
        a = rand_mat(); b = rand_mat(); ov_seen = 1'b0;
        mat_a = a; mat_b = b; in_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        repeat (3) begin @(negedge clk); in_valid = 1'b0; end
        nvec++; if (arr_a !== lane_col(a, 1)) begin nerr++; $display("FAIL midreset k1: got %h want %h", arr_a, lane_col(a, 1)); end
        #2 rst = 1'b0; #1;
        nvec++; if (arr_a !== '0 || arr_b !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL midreset abort: lanes %h/%h busy %b ov %b want 0", arr_a, arr_b, busy, out_valid);
        end
        @(negedge clk); rst = 1'b1;
        repeat (10) begin @(negedge clk); if (out_valid) ov_seen = 1'b1; end
        nvec++; if (ov_seen) begin nerr++; $display("FAIL midreset stale out_valid: got 1 want 0"); end
        a = rand_mat(); b = rand_mat();
        do_op(a, b, 1);
        check_op("after_reset", a, b);
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] a;
        logic [RW-1:0] e1, e2;
        a = seq_mat();
        for (int i = 0; i < N*N; i++) begin
            e1[i*CW +: CW] = CW'(a[i*DW +: DW]);
            e2[i*CW +: CW] = CW'(2 * int'(a[i*DW +: DW]));
        end
        do_op(a, ident(1), 0);
        check_op("b2b_1", a, ident(1));
        nvec++; if (c_got !== e1) begin nerr++; $display("FAIL b2b first: got %h want %h", c_got, e1); end
        nvec++; if (!rdy_after) begin nerr++; $display("FAIL b2b in_ready after hold: got 0 want 1"); end
        do_op(a, ident(2), 0);
        nvec++; if (acc_wait != 0) begin nerr++; $display("FAIL b2b accept wait: got %0d want 0", acc_wait); end
        nvec++; if (c_got !== e2) begin nerr++; $display("FAIL b2b second: got %h want %h", c_got, e2); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_basic();
        test_reset();
        test_random();
        test_hold();
        test_timeout();
        test_midreset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
